// File: rtl/if_id_stage.sv
// IF/ID pipeline register with a fetch handshake controller between the PC and instruction memory.
// Define IF_ID_PERF_EN to build the saturating fetch/bubble counters; otherwise Perf_* are tied to 0.
module if_id_stage #(
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic [31:0] IF_Addr,
    output logic [31:0] IM_Addr,
    output logic        IM_Req,
    input  logic        IM_Ack,
    input  logic [31:0] IM_Data,
    input  logic        ID_Stall,
    input  logic        Flush,
    output logic        PC_Stall,
    output logic [31:0] ID_Inst,
    output logic [31:0] ID_PC,
    output logic [31:0] ID_PCPlus4,
    output logic        ID_Valid,
    output logic [31:0] Perf_Fetched,
    output logic [31:0] Perf_Bubbles
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] hold_buf;
    logic        in_fetch;
    logic        in_hold;
    logic        accept;
    logic        bubble;

    assign in_fetch = (state == FETCH);
    assign in_hold  = (state == HOLD);
    assign accept   = ~Flush & ~ID_Stall & ((in_fetch & IM_Ack) | in_hold);
    assign bubble   = ~Flush & ~ID_Stall & ~accept;

    assign IM_Addr  = IF_Addr;
    assign IM_Req   = in_fetch;
    // NOTE: PC_Stall must see IM_Ack in the same cycle, so it stays combinational;
    // registering it would cost a cycle per instruction on zero-wait memory.
    assign PC_Stall = ~(accept | Flush);

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state      <= FETCH;
            hold_buf   <= '0;
            ID_Inst    <= NOP_INST;
            ID_PC      <= '0;
            ID_PCPlus4 <= '0;
            ID_Valid   <= 1'b0;
        end else if (Flush) begin
            ID_Inst    <= NOP_INST;
            ID_PC      <= '0;
            ID_PCPlus4 <= '0;
            ID_Valid   <= 1'b0;
            case (state)
                FETCH:   state <= IM_Ack ? FETCH : DROP;
                HOLD:    state <= FETCH;
                default: state <= DROP;
            endcase
        end else if (accept) begin
            ID_Inst    <= in_hold ? hold_buf : IM_Data;
            ID_PC      <= IF_Addr;
            ID_PCPlus4 <= IF_Addr + 32'd4;
            ID_Valid   <= 1'b1;
            state      <= FETCH;
        end else begin
            if (bubble) begin
                ID_Inst  <= NOP_INST;
                ID_Valid <= 1'b0;
            end
            // An ack in HOLD violates the memory protocol and is simply ignored.
            case (state)
                FETCH: begin
                    if (IM_Ack) begin
                        hold_buf <= IM_Data;
                        state    <= HOLD;
                    end
                end
                DROP: begin
                    if (IM_Ack) state <= FETCH;
                end
                default: state <= HOLD;
            endcase
        end
    end

`ifdef IF_ID_PERF_EN
    logic [31:0] fetched_cnt;
    logic [31:0] bubble_cnt;

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            fetched_cnt <= '0;
            bubble_cnt  <= '0;
        end else begin
            if (accept && fetched_cnt != 32'hFFFF_FFFF) fetched_cnt <= fetched_cnt + 32'd1;
            if (bubble && bubble_cnt != 32'hFFFF_FFFF)  bubble_cnt  <= bubble_cnt + 32'd1;
        end
    end

    assign Perf_Fetched = fetched_cnt;
    assign Perf_Bubbles = bubble_cnt;
`else
    assign Perf_Fetched = '0;
    assign Perf_Bubbles = '0;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed vector table, Clr-in-HOLD sequence, then randomized
// traffic against a flag-based model with a variable-latency memory.
module tb_if_id_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        Clk = 1'b0;
    logic        Clr;
    logic [31:0] IF_Addr;
    logic [31:0] IM_Addr;
    logic        IM_Req;
    logic        IM_Ack;
    logic [31:0] IM_Data;
    logic        ID_Stall;
    logic        Flush;
    logic        PC_Stall;
    logic [31:0] ID_Inst;
    logic [31:0] ID_PC;
    logic [31:0] ID_PCPlus4;
    logic        ID_Valid;
    logic [31:0] Perf_Fetched;
    logic [31:0] Perf_Bubbles;

    int total = 0;
    int bad   = 0;

    if_id_stage #(.NOP_INST(NOP)) dut (
        .Clk(Clk), .Clr(Clr), .IF_Addr(IF_Addr), .IM_Addr(IM_Addr), .IM_Req(IM_Req),
        .IM_Ack(IM_Ack), .IM_Data(IM_Data), .ID_Stall(ID_Stall), .Flush(Flush),
        .PC_Stall(PC_Stall), .ID_Inst(ID_Inst), .ID_PC(ID_PC), .ID_PCPlus4(ID_PCPlus4),
        .ID_Valid(ID_Valid), .Perf_Fetched(Perf_Fetched), .Perf_Bubbles(Perf_Bubbles)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_perf(input logic [31:0] fet, input logic [31:0] bub);
`ifdef IF_ID_PERF_EN
        check("perf_fetched", Perf_Fetched, fet);
        check("perf_bubbles", Perf_Bubbles, bub);
`else
        check("perf_fetched_tied", Perf_Fetched, 32'd0);
        check("perf_bubbles_tied", Perf_Bubbles, 32'd0);
`endif
    endtask

    typedef struct {
        logic        flush, stall, ack;
        logic [31:0] addr, data;
        logic        e_req, e_pcs;
        logic [31:0] e_inst, e_pc, e_p4;
        logic        e_valid;
        logic [31:0] e_fet, e_bub;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input logic fl, input logic st, input logic ak,
                                input logic [31:0] ad, input logic [31:0] dt,
                                input logic rq, input logic ps,
                                input logic [31:0] ins, input logic [31:0] pc,
                                input logic [31:0] p4, input logic vl,
                                input logic [31:0] fet, input logic [31:0] bub);
        vec_t v;
        v.flush = fl; v.stall = st; v.ack = ak; v.addr = ad; v.data = dt;
        v.e_req = rq; v.e_pcs = ps; v.e_inst = ins; v.e_pc = pc; v.e_p4 = p4;
        v.e_valid = vl; v.e_fet = fet; v.e_bub = bub;
        return v;
    endfunction

    // Reference model state (random phase)
    logic        m_drop, m_held;
    logic [31:0] m_held_word, m_inst, m_pc, m_p4, m_fet, m_bub;
    logic        m_valid;

    initial begin
        logic        busy;
        int          lat;
        logic [31:0] pc, tmp;
        logic        exp_req, exp_pcs, acc;

        vecs[0]  = mk(0,0,1, 32'h0000_0000, 32'h2000_0000, 1,0, 32'h2000_0000, 32'h0000_0000, 32'h0000_0004, 1, 1, 0);
        vecs[1]  = mk(0,0,1, 32'h0000_0004, 32'h2000_0004, 1,0, 32'h2000_0004, 32'h0000_0004, 32'h0000_0008, 1, 2, 0);
        vecs[2]  = mk(0,0,1, 32'h0000_0008, 32'h2000_0008, 1,0, 32'h2000_0008, 32'h0000_0008, 32'h0000_000C, 1, 3, 0);
        vecs[3]  = mk(0,0,0, 32'h0000_0010, 32'h0,         1,1, NOP,           32'h0000_0008, 32'h0000_000C, 0, 3, 1);
        vecs[4]  = mk(0,0,0, 32'h0000_0010, 32'h0,         1,1, NOP,           32'h0000_0008, 32'h0000_000C, 0, 3, 2);
        vecs[5]  = mk(0,0,0, 32'h0000_0010, 32'h0,         1,1, NOP,           32'h0000_0008, 32'h0000_000C, 0, 3, 3);
        vecs[6]  = mk(0,0,1, 32'h0000_0010, 32'hDEAD_0010, 1,0, 32'hDEAD_0010, 32'h0000_0010, 32'h0000_0014, 1, 4, 3);
        vecs[7]  = mk(0,1,1, 32'h0000_0014, 32'hCAFE_0014, 1,1, 32'hDEAD_0010, 32'h0000_0010, 32'h0000_0014, 1, 4, 3);
        vecs[8]  = mk(0,1,0, 32'h0000_0014, 32'h0,         0,1, 32'hDEAD_0010, 32'h0000_0010, 32'h0000_0014, 1, 4, 3);
        vecs[9]  = mk(0,0,0, 32'h0000_0014, 32'h0,         0,0, 32'hCAFE_0014, 32'h0000_0014, 32'h0000_0018, 1, 5, 3);
        vecs[10] = mk(0,0,0, 32'h0000_0020, 32'h0,         1,1, NOP,           32'h0000_0014, 32'h0000_0018, 0, 5, 4);
        vecs[11] = mk(1,0,0, 32'h0000_0020, 32'h0,         1,0, NOP,           32'h0,         32'h0,         0, 5, 4);
        vecs[12] = mk(0,0,0, 32'h0000_0080, 32'h0,         0,1, NOP,           32'h0,         32'h0,         0, 5, 5);
        vecs[13] = mk(0,0,1, 32'h0000_0080, 32'hBAD0_0020, 0,1, NOP,           32'h0,         32'h0,         0, 5, 6);
        vecs[14] = mk(0,0,1, 32'h0000_0080, 32'h2000_0080, 1,0, 32'h2000_0080, 32'h0000_0080, 32'h0000_0084, 1, 6, 6);
        vecs[15] = mk(1,0,1, 32'h0000_0084, 32'h1111_1111, 1,0, NOP,           32'h0,         32'h0,         0, 6, 6);
        vecs[16] = mk(0,0,0, 32'h0000_0100, 32'h0,         1,1, NOP,           32'h0,         32'h0,         0, 6, 7);
        vecs[17] = mk(0,0,1, 32'h0000_0100, 32'h2000_0100, 1,0, 32'h2000_0100, 32'h0000_0100, 32'h0000_0104, 1, 7, 7);
        vecs[18] = mk(0,0,1, 32'hFFFF_FFFC, 32'h7777_FFFC, 1,0, 32'h7777_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 1, 8, 7);

        Clr = 1'b1; IF_Addr = '0; IM_Ack = 1'b0; IM_Data = '0; ID_Stall = 1'b0; Flush = 1'b0;
        #12;
        check("rst_inst", ID_Inst, NOP);
        check("rst_valid", {31'd0, ID_Valid}, 32'd0);
        check("rst_pc", ID_PC, 32'd0);
        check("rst_pc4", ID_PCPlus4, 32'd0);
        check_perf(0, 0);
        @(posedge Clk); #1;
        Clr = 1'b0;
        check("rst_req", {31'd0, IM_Req}, 32'd1);

        for (int i = 0; i < 19; i++) begin
            Flush = vecs[i].flush; ID_Stall = vecs[i].stall; IM_Ack = vecs[i].ack;
            IF_Addr = vecs[i].addr; IM_Data = vecs[i].data;
            @(negedge Clk);
            check($sformatf("v%0d_req", i), {31'd0, IM_Req}, {31'd0, vecs[i].e_req});
            check($sformatf("v%0d_pcstall", i), {31'd0, PC_Stall}, {31'd0, vecs[i].e_pcs});
            check($sformatf("v%0d_imaddr", i), IM_Addr, vecs[i].addr);
            @(posedge Clk); #1;
            check($sformatf("v%0d_inst", i), ID_Inst, vecs[i].e_inst);
            check($sformatf("v%0d_pc", i), ID_PC, vecs[i].e_pc);
            check($sformatf("v%0d_pc4", i), ID_PCPlus4, vecs[i].e_p4);
            check($sformatf("v%0d_valid", i), {31'd0, ID_Valid}, {31'd0, vecs[i].e_valid});
            check_perf(vecs[i].e_fet, vecs[i].e_bub);
        end

        // Clr while in HOLD: outputs must return to reset values without a clock edge.
        Flush = 1'b0; ID_Stall = 1'b1; IM_Ack = 1'b1; IF_Addr = 32'h0000_0200; IM_Data = 32'h1234_5678;
        @(posedge Clk); #1;
        IM_Ack = 1'b0;
        check("hold_req_low", {31'd0, IM_Req}, 32'd0);
        check("hold_inst_kept", ID_Inst, 32'h7777_FFFC);
        #2 Clr = 1'b1;
        #1;
        check("clr_req", {31'd0, IM_Req}, 32'd1);
        check("clr_inst", ID_Inst, NOP);
        check("clr_valid", {31'd0, ID_Valid}, 32'd0);
        check("clr_pc", ID_PC, 32'd0);
        check("clr_pc4", ID_PCPlus4, 32'd0);
        check("clr_pcstall", {31'd0, PC_Stall}, 32'd1);
        check_perf(0, 0);
        @(posedge Clk); #1;
        Clr = 1'b0; ID_Stall = 1'b0;

        // Randomized phase against the model; the bench also plays PC register and memory.
        m_drop = 0; m_held = 0; m_held_word = '0; m_inst = NOP; m_pc = '0; m_p4 = '0;
        m_valid = 0; m_fet = '0; m_bub = '0;
        busy = 0; lat = 0; pc = 32'h0000_1000;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            exp_req = !m_drop && !m_held;
            if (!busy && exp_req) begin
                busy = 1;
                lat = $urandom_range(0, 3);
            end
            IF_Addr  = pc;
            IM_Ack   = busy && (lat == 0);
            IM_Data  = $urandom;
            Flush    = ($urandom_range(0, 7) == 0);
            ID_Stall = ($urandom_range(0, 3) == 0);
            // A flush colliding with the stale ack would leave the block waiting forever.
            if (m_drop && IM_Ack) Flush = 1'b0;

            acc     = !Flush && !ID_Stall && ((exp_req && IM_Ack) || m_held);
            exp_pcs = !(acc || Flush);

            @(negedge Clk);
            check("rnd_req", {31'd0, IM_Req}, {31'd0, exp_req});
            check("rnd_pcstall", {31'd0, PC_Stall}, {31'd0, exp_pcs});
            check("rnd_imaddr", IM_Addr, pc);

            if (Flush) begin
                m_inst = NOP; m_valid = 0; m_pc = '0; m_p4 = '0;
                if (m_held) m_held = 0;
                else if (!m_drop && !IM_Ack) m_drop = 1;
            end else if (acc) begin
                m_inst = m_held ? m_held_word : IM_Data;
                m_pc = pc; m_p4 = pc + 32'd4; m_valid = 1; m_held = 0;
                if (m_fet != 32'hFFFF_FFFF) m_fet = m_fet + 1;
            end else begin
                if (!ID_Stall) begin
                    m_inst = NOP; m_valid = 0;
                    if (m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 1;
                end
                if (exp_req && IM_Ack) begin
                    m_held = 1; m_held_word = IM_Data;
                end
                if (m_drop && IM_Ack) m_drop = 0;
            end

            @(posedge Clk); #1;
            check("rnd_inst", ID_Inst, m_inst);
            check("rnd_pc", ID_PC, m_pc);
            check("rnd_pc4", ID_PCPlus4, m_p4);
            check("rnd_valid", {31'd0, ID_Valid}, {31'd0, m_valid});
            check_perf(m_fet, m_bub);

            if (IM_Ack) busy = 0;
            else if (busy) lat--;
            if (!exp_pcs) begin
                if (Flush) begin
                    tmp = $urandom;
                    pc = tmp & 32'hFFFF_FFFC;
                end else begin
                    pc = pc + 32'd4;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
